// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the ID-stage hazard unit and the pipeline.
interface hazard_stall_unit_if #(
   parameter int unsigned NB_REG_ADDR = 5,
   parameter int unsigned NB_PERF     = 32
);
   logic                   i_valid_id;
   logic [NB_REG_ADDR-1:0] i_rs;
   logic [NB_REG_ADDR-1:0] i_rt;
   logic                   i_uses_rt;
   logic                   i_mem_read_ex;
   logic [NB_REG_ADDR-1:0] i_rd_ex;
   logic                   i_branch_taken;
   logic                   i_mem_busy;
   logic                   i_halt_instr;
   logic                   i_halt_req;
   logic                   i_resume;
   logic                   o_pc_we;
   logic                   o_if_id_we;
   logic                   o_if_id_flush;
   logic                   o_id_ex_bubble;
   logic                   o_ex_mem_we;
   logic                   o_halted;
   logic [NB_PERF-1:0]     o_stall_cycles;

   // Pipeline side: drives hazard inputs, consumes enables
   modport master (
      output i_valid_id, i_rs, i_rt, i_uses_rt, i_mem_read_ex, i_rd_ex,
             i_branch_taken, i_mem_busy, i_halt_instr, i_halt_req, i_resume,
      input  o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble, o_ex_mem_we,
             o_halted, o_stall_cycles
   );

   // Hazard unit side
   modport slave (
      input  i_valid_id, i_rs, i_rt, i_uses_rt, i_mem_read_ex, i_rd_ex,
             i_branch_taken, i_mem_busy, i_halt_instr, i_halt_req, i_resume,
      output o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble, o_ex_mem_we,
             o_halted, o_stall_cycles
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Resolves hazards forwarding cannot: load-use stalls, memory-wait freezes,
// branch flushes, and drain-to-halt on HALT or debug request.
module hazard_stall_unit #(
   parameter int unsigned NB_REG_ADDR  = 5,
   parameter int unsigned NB_PERF      = 32,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input logic                i_clock,
   input logic                i_reset,
   hazard_stall_unit_if.slave hs
);
   localparam int unsigned NB_DRAIN = (DRAIN_CYCLES < 3) ? 1 : $clog2(DRAIN_CYCLES);
   localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

   state_t               state_q, state_d;
   logic [NB_DRAIN-1:0]  drain_q, drain_d;
   logic [NB_PERF-1:0]   stall_q;
   logic                 load_use;
   logic                 halt_go;
   logic                 pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, halted;

   // Load-use: EX load targets a register the ID instruction reads (r0 never hazards)
   assign load_use = hs.i_valid_id & hs.i_mem_read_ex & (hs.i_rd_ex != '0) &
                     ((hs.i_rs == hs.i_rd_ex) | (hs.i_uses_rt & (hs.i_rt == hs.i_rd_ex)));
   assign halt_go  = (hs.i_halt_instr & hs.i_valid_id) | hs.i_halt_req;

   // State and drain counter register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Next-state and same-cycle enable generation
   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      ex_mem_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      halted       = 1'b0;
      case (state_q)
         // MEM_WAIT with memory released behaves exactly like RUN
         RUN, MEM_WAIT: begin
            state_d = RUN;
            if (hs.i_mem_busy) begin
               pc_we     = 1'b0;
               if_id_we  = 1'b0;
               ex_mem_we = 1'b0;
               state_d   = MEM_WAIT;
            end else if (load_use) begin
               pc_we        = 1'b0;
               if_id_we     = 1'b0;
               id_ex_bubble = 1'b1;
            end else if (halt_go) begin
               pc_we        = 1'b0;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               drain_d      = DRAIN_LOAD;
               state_d      = DRAIN;
            end else if (hs.i_branch_taken) begin
               if_id_flush = 1'b1;
            end
         end
         DRAIN: begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if (hs.i_mem_busy) begin
               ex_mem_we = 1'b0;
            end else begin
               if (drain_q <= NB_DRAIN'(1)) state_d = HALTED;
               if (drain_q != '0) drain_d = drain_q - NB_DRAIN'(1);
            end
         end
         HALTED: begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
            halted    = 1'b1;
            if (hs.i_resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Pipe runs freely while reset is held
      if (!i_reset) begin
         pc_we        = 1'b1;
         if_id_we     = 1'b1;
         ex_mem_we    = 1'b1;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
         halted       = 1'b0;
      end
   end

   // Saturating stall-cycle counter; halted cycles are not stalls
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         stall_q <= '0;
      end else if (!pc_we && (state_q != HALTED) && (stall_q != '1)) begin
         stall_q <= stall_q + NB_PERF'(1);
      end
   end

   assign hs.o_pc_we        = pc_we;
   assign hs.o_if_id_we     = if_id_we;
   assign hs.o_if_id_flush  = if_id_flush;
   assign hs.o_id_ex_bubble = id_ex_bubble;
   assign hs.o_ex_mem_we    = ex_mem_we;
   assign hs.o_halted       = halted;
   assign hs.o_stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit against a behavioural model.
module tb_hazard_stall_unit;
   localparam int unsigned DRAIN_CYCLES = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   // Model: draining counts remaining drain cycles; waiting on memory needs no state
   bit          m_halted;
   int          m_drain_left;
   logic [31:0] m_stall;
   logic        hreq_level;

   always #5 clk = ~clk;

   hazard_stall_unit_if #(.NB_REG_ADDR(5), .NB_PERF(32)) hs ();
   hazard_stall_unit_if #(.NB_REG_ADDR(5), .NB_PERF(4))  hs4 ();

   hazard_stall_unit #(.NB_REG_ADDR(5), .NB_PERF(32), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .hs      (hs.slave)
   );

   hazard_stall_unit #(.NB_REG_ADDR(5), .NB_PERF(4), .DRAIN_CYCLES(DRAIN_CYCLES)) dut4 (
      .i_clock (clk),
      .i_reset (rst_n),
      .hs      (hs4.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      hs.i_valid_id     = 1'b1;
      hs.i_rs           = 5'd1;
      hs.i_rt           = 5'd2;
      hs.i_uses_rt      = 1'b1;
      hs.i_mem_read_ex  = 1'b0;
      hs.i_rd_ex        = 5'd3;
      hs.i_branch_taken = 1'b0;
      hs.i_mem_busy     = 1'b0;
      hs.i_halt_instr   = 1'b0;
      hs.i_halt_req     = 1'b0;
      hs.i_resume       = 1'b0;
   endtask

   // Called just after a falling edge with inputs applied; ends at next falling edge
   task automatic tick();
      bit busy, lu, e_pc, e_ifid, e_ex, e_fl, e_bb, e_h;
      #1;
      busy = hs.i_mem_busy;
      lu = hs.i_valid_id && hs.i_mem_read_ex && (hs.i_rd_ex != 0) &&
           ((hs.i_rs == hs.i_rd_ex) || (hs.i_uses_rt && (hs.i_rt == hs.i_rd_ex)));
      {e_pc, e_ifid, e_ex, e_fl, e_bb, e_h} = 6'b111_000;
      if (m_halted) begin
         {e_pc, e_ifid, e_ex, e_fl, e_bb, e_h} = 6'b000_001;
      end else if (m_drain_left > 0) begin
         {e_pc, e_ifid, e_ex, e_fl, e_bb} = {3'b000, 1'b0, 1'b1};
         e_ex = !busy;
      end else if (busy) begin
         {e_pc, e_ifid, e_ex} = 3'b000;
      end else if (lu) begin
         {e_pc, e_ifid, e_bb} = 3'b001;
      end else if ((hs.i_halt_instr && hs.i_valid_id) || hs.i_halt_req) begin
         {e_pc, e_fl, e_bb} = 3'b011;
      end else if (hs.i_branch_taken) begin
         e_fl = 1'b1;
      end
      check_eq("pc_we",     32'(hs.o_pc_we),        32'(e_pc));
      check_eq("if_id_we",  32'(hs.o_if_id_we),     32'(e_ifid));
      check_eq("ex_mem_we", 32'(hs.o_ex_mem_we),    32'(e_ex));
      check_eq("flush",     32'(hs.o_if_id_flush),  32'(e_fl));
      check_eq("bubble",    32'(hs.o_id_ex_bubble), 32'(e_bb));
      check_eq("halted",    32'(hs.o_halted),       32'(e_h));
      check_eq("stall_cnt", hs.o_stall_cycles,      m_stall);
      if (!e_pc && !m_halted && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      if (m_halted) begin
         if (hs.i_resume) m_halted = 1'b0;
      end else if (m_drain_left > 0) begin
         if (!busy) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
         end
      end else if (!busy && !lu && ((hs.i_halt_instr && hs.i_valid_id) || hs.i_halt_req)) begin
         m_drain_left = int'(DRAIN_CYCLES) - 1;
      end
      @(negedge clk);
   endtask

   // Reset applied at a falling edge with hostile inputs; outputs must be forced
   task automatic apply_reset();
      rst_n = 1'b0;
      hs.i_mem_busy    = 1'b1;
      hs.i_halt_req    = 1'b1;
      hs.i_mem_read_ex = 1'b1;
      hs.i_rd_ex       = hs.i_rs;
      #1;
      check_eq("rst_pc_we",  32'(hs.o_pc_we),        32'd1);
      check_eq("rst_ifid",   32'(hs.o_if_id_we),     32'd1);
      check_eq("rst_ex_mem", 32'(hs.o_ex_mem_we),    32'd1);
      check_eq("rst_flush",  32'(hs.o_if_id_flush),  32'd0);
      check_eq("rst_bubble", 32'(hs.o_id_ex_bubble), 32'd0);
      check_eq("rst_halted", 32'(hs.o_halted),       32'd0);
      check_eq("rst_stall",  hs.o_stall_cycles,      32'd0);
      m_halted = 1'b0; m_drain_left = 0; m_stall = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      idle();
      hs4.i_valid_id = 1'b0; hs4.i_rs = '0; hs4.i_rt = '0; hs4.i_uses_rt = 1'b0;
      hs4.i_mem_read_ex = 1'b0; hs4.i_rd_ex = '0; hs4.i_branch_taken = 1'b0;
      hs4.i_mem_busy = 1'b0; hs4.i_halt_instr = 1'b0; hs4.i_halt_req = 1'b0;
      hs4.i_resume = 1'b0;
      hreq_level = 1'b0;
      @(negedge clk);
      apply_reset();

      // Load-use on r5 stalls exactly one cycle
      hs.i_mem_read_ex = 1'b1; hs.i_rd_ex = 5'd5; hs.i_rs = 5'd5; tick();
      idle(); tick();
      check_eq("lu_count", hs.o_stall_cycles, 32'd1);

      // r0 and unused rt never hazard
      hs.i_mem_read_ex = 1'b1; hs.i_rd_ex = 5'd0; hs.i_rs = 5'd0; tick();
      hs.i_rd_ex = 5'd7; hs.i_rt = 5'd7; hs.i_uses_rt = 1'b0; hs.i_rs = 5'd1; tick();

      // Memory wait 4 cycles, load-use on release
      idle(); hs.i_mem_busy = 1'b1;
      repeat (4) tick();
      hs.i_mem_busy = 1'b0; hs.i_mem_read_ex = 1'b1; hs.i_rd_ex = 5'd2; tick();
      idle(); tick();

      // Branch with load-use: stall wins; branch alone flushes
      hs.i_branch_taken = 1'b1; hs.i_mem_read_ex = 1'b1; hs.i_rd_ex = 5'd1; tick();
      idle(); hs.i_branch_taken = 1'b1; tick();
      idle(); tick();

      // HALT instruction, drain, halt, resume
      hs.i_halt_instr = 1'b1; tick();
      idle(); hs.i_branch_taken = 1'b1; repeat (2) tick();
      idle(); tick();
      check_eq("halted_4th", 32'(hs.o_halted), 32'd1);
      hs.i_resume = 1'b1; tick();
      idle(); tick();

      // Debug halt with a 1-cycle memory freeze mid-drain
      hs.i_halt_req = 1'b1; tick();
      hs.i_halt_req = 1'b0; hs.i_mem_busy = 1'b1; tick();
      hs.i_mem_busy = 1'b0; repeat (3) tick();
      hs.i_resume = 1'b1; tick();
      idle(); tick();

      // Reset mid-drain
      hs.i_halt_instr = 1'b1; tick();
      idle(); tick();
      apply_reset();

      // Random traffic with small register space to provoke hazards
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 249) == 0) apply_reset();
         if ($urandom_range(0, 29) == 0) hreq_level = ~hreq_level;
         hs.i_valid_id     = ($urandom_range(0, 9) != 0);
         hs.i_rs           = 5'($urandom_range(0, 3));
         hs.i_rt           = 5'($urandom_range(0, 3));
         hs.i_uses_rt      = 1'($urandom_range(0, 1));
         hs.i_mem_read_ex  = ($urandom_range(0, 2) == 0);
         hs.i_rd_ex        = 5'($urandom_range(0, 3));
         hs.i_branch_taken = ($urandom_range(0, 4) == 0);
         hs.i_mem_busy     = ($urandom_range(0, 5) == 0);
         hs.i_halt_instr   = ($urandom_range(0, 19) == 0);
         hs.i_halt_req     = hreq_level;
         hs.i_resume       = ($urandom_range(0, 3) == 0);
         tick();
      end

      // Narrow counter saturates at 15 after 20 stalled cycles
      idle();
      hs4.i_mem_busy = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check_eq("perf4_sat", 32'(hs4.o_stall_cycles), 32'd15);
      check_eq("perf4_pc",  32'(hs4.o_pc_we),        32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
